noc_network_interface: RTL and testbench
========================================

// Module: noc_network_interface
// PURPOSE
//  Endpoint NI for one mesh node: the PE-facing end of the router's local port.
//  TX: packs PE payload + destination into a flit and injects it on the router local input.
//  RX: accepts flits from the router local output, checks the destination,
//      unpacks them and hands them to the PE.
//  Both directions are buffered, each by its own FIFO.
// PARAMETERS
//  DATA_WIDTH  216  flit width; payload width PW = DATA_WIDTH-4*POS_WIDTH
//  POS_WIDTH   4    width of each X/Y coordinate field
//  POS_X       0    this node's X coordinate
//  POS_Y       0    this node's Y coordinate
//  TX_DEPTH    4    TX FIFO entries; power of 2, >=2
//  RX_DEPTH    4    RX FIFO entries; power of 2, >=2
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           async reset, active-high
//  tx_valid         in   1           PE has a packet to send
//  tx_ready         out  1           NI accepts tx packet this cycle
//  tx_dst_x         in   POS_WIDTH   destination X
//  tx_dst_y         in   POS_WIDTH   destination Y
//  tx_payload       in   PW          payload
//  local_in_port    out  DATA_WIDTH  flit to router local input
//  local_in_valid   out  1           flit valid
//  local_in_busy    in   1           router local input cannot accept
//  local_out_port   in   DATA_WIDTH  flit from router local output
//  local_out_valid  in   1           flit valid
//  local_out_busy   out  1           NI cannot accept flit
//  rx_valid         out  1           packet available to PE
//  rx_ready         in   1           PE takes packet this cycle
//  rx_src_x         out  POS_WIDTH   source X of head packet
//  rx_src_y         out  POS_WIDTH   source Y of head packet
//  rx_payload       out  PW          payload of head packet
//  tx_count         out  16          flits injected, saturating
//  rx_count         out  16          flits delivered to PE, saturating
//  drop_count       out  16          misrouted flits dropped, saturating
// BEHAVIOUR
//  Flit format, MSB first: {dst_x, dst_y, src_x, src_y, payload[PW-1:0]}.
//  Handshake on all links: a transfer occurs on a rising edge with valid=1 and busy=0
//   (or valid=1 and ready=1 on the PE side).
//   While valid=1 and the transfer has not occurred, the sender holds valid and data stable.
//  Reset: all FIFOs empty and all counters 0.
//   Outputs during reset: tx_ready=1, local_in_valid=0, local_out_busy=0, rx_valid=0.
//   Data outputs are 0.
//  TX path:
//   - tx_ready = !tx_full; tx_full = (tx_cnt == TX_DEPTH).
//   - On push, the FIFO stores flit {tx_dst_x, tx_dst_y, POS_X, POS_Y, tx_payload}.
//   - local_in_valid = !tx_empty; local_in_port = FIFO head, registered storage.
//   - Pop on local_in_valid && !local_in_busy.
//   - Latency: packet accepted at edge N appears on local_in_port after edge N, so it can
//     be taken at edge N+1 at the earliest.
//   - Push and pop in the same cycle keep tx_cnt unchanged and are legal at any non-full level.
//   - Full: tx_ready=0, so no push occurs.
//   - Pointers wrap modulo TX_DEPTH.
//   - dst == own node is legal: the router loops it back to the local port.
//  RX path:
//   - local_out_busy = (rx_cnt == RX_DEPTH), decoded combinationally from the registered count.
//   - Accept on local_out_valid && !local_out_busy.
//   - Check: if flit dst_x == POS_X and dst_y == POS_Y, the flit is pushed to the RX FIFO.
//   - Otherwise the flit is consumed, not stored, and drop_count increments.
//   - rx_valid = !rx_empty; rx_src_x, rx_src_y and rx_payload come from the FIFO head.
//   - Pop on rx_valid && rx_ready; rx_count increments on pop.
//   - Latency: flit accepted at edge N gives rx_valid=1 after edge N.
//   - Simultaneous push and pop while full is impossible, because busy=1 blocks the push.
//   - The PE may pop at full, which frees the slot one cycle later.
//  Counters:
//   - tx_count increments on each local_in pop.
//   - Each counter saturates at 16'hFFFF and holds there.
//  TX and RX are independent; neither stalls the other.
//  An asserted rst mid-transfer discards all buffered flits immediately;
//   no partial state survives.
// TESTING
//  1. POS=(1,2); send dst(3,0), payload 0xAB while local_in_busy=0.
//     -> local_in_port = {4'h3,4'h0,4'h1,4'h2,200'hAB}, valid for 1 cycle; tx_count=1.
//  2. Hold local_in_busy=1 and offer 6 tx packets.
//     -> tx_ready drops after 4 accepted.
//     -> Release busy: 4 flits leave in order, 1 per cycle.
//  3. Inject 5 flits addressed to (1,2) with rx_ready=0.
//     -> local_out_busy=1 after the 4th is accepted; the 5th is held.
//     -> Set rx_ready=1: all 5 delivered in order; rx_count=5.
//  4. Inject a flit addressed to (2,2).
//     -> rx_valid stays 0; drop_count=1; local_out_busy stays 0.
//  5. Fill both FIFOs half-way, then pulse rst.
//     -> All valids 0, tx_ready=1, counters 0 on the same cycle as rst.
//  6. Force drop_count to 16'hFFFE and inject 3 misrouted flits.
//     -> drop_count reads 16'hFFFF.

Source files
------------

// File: rtl/noc_network_interface.sv
// Endpoint network interface for one mesh node: packs PE packets into flits for the
// router local input and unpacks/filters flits from the router local output for the PE.
module noc_network_interface #(
  parameter int DATA_WIDTH = 216,
  parameter int POS_WIDTH  = 4,
  parameter int POS_X      = 0,
  parameter int POS_Y      = 0,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  localparam int PW        = DATA_WIDTH - 4*POS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // PE transmit side
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [POS_WIDTH-1:0]  tx_dst_x,
  input  logic [POS_WIDTH-1:0]  tx_dst_y,
  input  logic [PW-1:0]         tx_payload,
  // router local input
  output logic [DATA_WIDTH-1:0] local_in_port,
  output logic                  local_in_valid,
  input  logic                  local_in_busy,
  // router local output
  input  logic [DATA_WIDTH-1:0] local_out_port,
  input  logic                  local_out_valid,
  output logic                  local_out_busy,
  // PE receive side
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [POS_WIDTH-1:0]  rx_src_x,
  output logic [POS_WIDTH-1:0]  rx_src_y,
  output logic [PW-1:0]         rx_payload,
  // statistics
  output logic [15:0]           tx_count,
  output logic [15:0]           rx_count,
  output logic [15:0]           drop_count
);

  // Handshake: a transfer happens on a rising edge where valid=1 and busy=0 (router links)
  // or valid=1 and ready=1 (PE links); an offered item stays stable until it transfers.

  localparam int TAW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  // RX entries drop the destination fields: they are known to match this node.
  localparam int RW  = DATA_WIDTH - 2*POS_WIDTH;

  localparam logic [POS_WIDTH-1:0] OWN_X = POS_WIDTH'(POS_X);
  localparam logic [POS_WIDTH-1:0] OWN_Y = POS_WIDTH'(POS_Y);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------- TX path ----------------
  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0]        tx_wr_ptr, tx_rd_ptr;
  logic [TAW:0]          tx_cnt;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_flit;
  logic [15:0]           tx_cnt_stat;

  assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  assign tx_pop   = local_in_valid && !local_in_busy;
  assign tx_flit  = {tx_dst_x, tx_dst_y, OWN_X, OWN_Y, tx_payload};

  assign local_in_valid = !tx_empty;
  assign local_in_port  = tx_empty ? '0 : tx_mem[tx_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_cnt      <= '0;
      tx_cnt_stat <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop) begin
        tx_rd_ptr   <= tx_rd_ptr + 1'b1;
        tx_cnt_stat <= sat_inc(tx_cnt_stat);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_flit;
  end

  // ---------------- RX path ----------------
  logic [RW-1:0]          rx_mem [RX_DEPTH];
  logic [RAW-1:0]         rx_wr_ptr, rx_rd_ptr;
  logic [RAW:0]           rx_cnt;
  logic                   rx_empty, rx_accept, rx_match, rx_push, rx_drop, rx_pop;
  logic [POS_WIDTH-1:0]   in_dst_x, in_dst_y;
  logic [RW-1:0]          rx_head;
  logic [15:0]            rx_cnt_stat;
  logic [15:0]            drop_cnt;

  assign in_dst_x = local_out_port[DATA_WIDTH-1 -: POS_WIDTH];
  assign in_dst_y = local_out_port[DATA_WIDTH-POS_WIDTH-1 -: POS_WIDTH];

  assign local_out_busy = (rx_cnt == (RAW+1)'(RX_DEPTH));
  assign rx_empty       = (rx_cnt == '0);
  assign rx_accept      = local_out_valid && !local_out_busy;
  assign rx_match       = (in_dst_x == OWN_X) && (in_dst_y == OWN_Y);
  assign rx_push        = rx_accept && rx_match;
  assign rx_drop        = rx_accept && !rx_match;
  assign rx_valid       = !rx_empty;
  assign rx_pop         = rx_valid && rx_ready;

  assign rx_head    = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign rx_src_x   = rx_head[RW-1 -: POS_WIDTH];
  assign rx_src_y   = rx_head[RW-POS_WIDTH-1 -: POS_WIDTH];
  assign rx_payload = rx_head[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_cnt      <= '0;
      rx_cnt_stat <= '0;
      drop_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop) begin
        rx_rd_ptr   <= rx_rd_ptr + 1'b1;
        rx_cnt_stat <= sat_inc(rx_cnt_stat);
      end
      if (rx_drop) drop_cnt <= sat_inc(drop_cnt);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= local_out_port[RW-1:0];
  end

  assign tx_count   = tx_cnt_stat;
  assign rx_count   = rx_cnt_stat;
  assign drop_count = drop_cnt;

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed bench for noc_network_interface at node (1,2): vector tables for single
// packets plus hand-written sequences for fill/drain, saturation and reset.
module tb_noc_network_interface;

  localparam int DW = 216;
  localparam int PW = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic          tx_ready;
  logic [3:0]    tx_dst_x, tx_dst_y;
  logic [PW-1:0] tx_payload;
  logic [DW-1:0] local_in_port;
  logic          local_in_valid;
  logic          local_in_busy;
  logic [DW-1:0] local_out_port;
  logic          local_out_valid;
  logic          local_out_busy;
  logic          rx_valid;
  logic          rx_ready;
  logic [3:0]    rx_src_x, rx_src_y;
  logic [PW-1:0] rx_payload;
  logic [15:0]   tx_count, rx_count, drop_count;

  noc_network_interface #(
    .DATA_WIDTH(DW), .POS_WIDTH(4), .POS_X(1), .POS_Y(2), .TX_DEPTH(4), .RX_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
    .tx_payload(tx_payload),
    .local_in_port(local_in_port), .local_in_valid(local_in_valid), .local_in_busy(local_in_busy),
    .local_out_port(local_out_port), .local_out_valid(local_out_valid),
    .local_out_busy(local_out_busy),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_x(rx_src_x), .rx_src_y(rx_src_y),
    .rx_payload(rx_payload),
    .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [207:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_idle_reset();
    check("rst_tx_ready",       tx_ready,       1);
    check("rst_local_in_valid", local_in_valid, 0);
    check("rst_local_out_busy", local_out_busy, 0);
    check("rst_rx_valid",       rx_valid,       0);
    check("rst_local_in_port",  local_in_port,  0);
    check("rst_rx_payload",     {rx_src_x, rx_src_y, rx_payload}, 0);
    check("rst_tx_count",       tx_count,       0);
    check("rst_rx_count",       rx_count,       0);
    check("rst_drop_count",     drop_count,     0);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [3:0]    dx;
    logic [3:0]    dy;
    logic [PW-1:0] pl;
    logic [DW-1:0] flit;
  } tx_vec_t;

  typedef struct {
    logic [DW-1:0] flit;
    logic          keep;
    logic [3:0]    sx;
    logic [3:0]    sy;
    logic [PW-1:0] pl;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[5];

  initial begin
    int acc, acc_now, k, e, exp_drop;
    logic sent, pop;

    tx_tab[0] = '{4'h3, 4'h0, 200'hAB,        {4'h3, 4'h0, 4'h1, 4'h2, 200'hAB}};
    tx_tab[1] = '{4'h1, 4'h2, 200'h1234,      {4'h1, 4'h2, 4'h1, 4'h2, 200'h1234}};
    tx_tab[2] = '{4'hF, 4'hF, {200{1'b1}},    {4'hF, 4'hF, 4'h1, 4'h2, {200{1'b1}}}};
    tx_tab[3] = '{4'h0, 4'h7, 200'hDEADBEEF,  {4'h0, 4'h7, 4'h1, 4'h2, 200'hDEADBEEF}};

    rx_tab[0] = '{{4'h2, 4'h2, 4'h5, 4'h6, 200'h11}, 1'b0, 4'h0, 4'h0, 200'h0};
    rx_tab[1] = '{{4'h1, 4'h2, 4'h3, 4'h4, 200'h22}, 1'b1, 4'h3, 4'h4, 200'h22};
    rx_tab[2] = '{{4'h1, 4'h3, 4'h0, 4'h0, 200'h33}, 1'b0, 4'h0, 4'h0, 200'h0};
    rx_tab[3] = '{{4'h0, 4'h2, 4'h7, 4'h7, 200'h44}, 1'b0, 4'h0, 4'h0, 200'h0};
    rx_tab[4] = '{{4'h1, 4'h2, 4'hE, 4'hF, 200'h55}, 1'b1, 4'hE, 4'hF, 200'h55};

    // reset
    rst = 1'b1;
    tx_valid = 0; tx_dst_x = 0; tx_dst_y = 0; tx_payload = '0;
    local_in_busy = 0; local_out_port = '0; local_out_valid = 0; rx_ready = 0;
    repeat (2) @(negedge clk);
    check_idle_reset();
    rst = 1'b0;
    @(negedge clk);

    // single TX packets, each leaves the next cycle
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1; tx_dst_x = tx_tab[i].dx; tx_dst_y = tx_tab[i].dy; tx_payload = tx_tab[i].pl;
      check("tx_ready_idle", tx_ready, 1);
      @(negedge clk);
      tx_valid = 0;
      check("tx_vec_valid", local_in_valid, 1);
      check("tx_vec_flit", local_in_port, tx_tab[i].flit);
      @(negedge clk);
      check("tx_vec_valid_gone", local_in_valid, 0);
      check("tx_vec_count", tx_count, i + 1);
    end

    // TX back-pressure: fill to 4, then drain in order
    local_in_busy = 1; acc = 0;
    for (int c = 0; c < 6; c++) begin
      tx_valid = 1; tx_dst_x = 4'h5; tx_dst_y = 4'h6; tx_payload = 200'(100 + acc);
      acc_now = tx_ready ? 1 : 0;
      @(negedge clk);
      acc += acc_now;
    end
    tx_valid = 0;
    check("tx_accepted_when_busy", acc, 4);
    check("tx_ready_full", tx_ready, 0);
    check("tx_valid_busy", local_in_valid, 1);
    local_in_busy = 0;
    for (int j = 0; j < 4; j++) begin
      check("tx_drain_valid", local_in_valid, 1);
      check("tx_drain_flit", local_in_port, {4'h5, 4'h6, 4'h1, 4'h2, 200'(100 + j)});
      @(negedge clk);
    end
    check("tx_drain_empty", local_in_valid, 0);
    check("tx_count_after_drain", tx_count, 8);

    // RX fill to full with rx_ready=0, 5th flit held, then drain all 5
    rx_ready = 0; k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      local_out_valid = 1;
      local_out_port = {4'h1, 4'h2, 4'(k), 4'(k + 1), 200'(200 + k)};
      acc_now = local_out_busy ? 0 : 1;
      @(negedge clk);
      if (acc_now == 1) begin
        exp_q.push_back({4'(k), 4'(k + 1), 200'(200 + k)});
        k++;
      end
    end
    check("rx_fill_count", k, 4);
    check("rx_busy_full", local_out_busy, 1);
    local_out_port = {4'h1, 4'h2, 4'h4, 4'h5, 200'(204)};
    repeat (2) @(negedge clk);
    check("rx_busy_held", local_out_busy, 1);
    check("rx_count_before", rx_count, 0);
    rx_ready = 1; e = 0;
    for (int c = 0; c < 15 && e < 5; c++) begin
      sent = local_out_valid && !local_out_busy;
      pop  = rx_valid;
      if (pop) begin
        if (exp_q.size() == 0) check("rx_unexpected", rx_valid, 0);
        else check("rx_order", {rx_src_x, rx_src_y, rx_payload}, exp_q[0]);
      end
      @(negedge clk);
      if (sent) begin
        local_out_valid = 0;
        exp_q.push_back({4'h4, 4'h5, 200'(204)});
      end
      if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pop) e++;
    end
    rx_ready = 0;
    check("rx_delivered", e, 5);
    check("rx_count_5", rx_count, 5);
    check("rx_empty_after", rx_valid, 0);
    check("rx_queue_left", exp_q.size(), 0);

    // RX table: destination filter and drop counter
    exp_drop = 0;
    for (int i = 0; i < 5; i++) begin
      local_out_valid = 1; local_out_port = rx_tab[i].flit;
      check("rx_vec_busy", local_out_busy, 0);
      @(negedge clk);
      local_out_valid = 0;
      if (!rx_tab[i].keep) exp_drop++;
      check("rx_vec_valid", rx_valid, rx_tab[i].keep);
      check("rx_vec_drop_count", drop_count, exp_drop);
      if (rx_tab[i].keep) begin
        check("rx_vec_fields", {rx_src_x, rx_src_y, rx_payload},
              {rx_tab[i].sx, rx_tab[i].sy, rx_tab[i].pl});
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
        check("rx_vec_popped", rx_valid, 0);
      end
    end
    check("rx_count_7", rx_count, 7);

    // drop counter saturation
    force dut.drop_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.drop_cnt;
    check("drop_preset", drop_count, 16'hFFFE);
    local_out_valid = 1; local_out_port = {4'h9, 4'h9, 4'h0, 4'h0, 200'h77};
    @(negedge clk);
    check("drop_reach_max", drop_count, 16'hFFFF);
    repeat (2) @(negedge clk);
    local_out_valid = 0;
    check("drop_saturated", drop_count, 16'hFFFF);
    check("drop_no_rx", rx_valid, 0);

    // reset with both FIFOs half full
    local_in_busy = 1; rx_ready = 0;
    tx_valid = 1; tx_dst_x = 4'h2; tx_dst_y = 4'h3; tx_payload = 200'h5A;
    local_out_valid = 1; local_out_port = {4'h1, 4'h2, 4'h6, 4'h6, 200'hA5};
    repeat (2) @(negedge clk);
    tx_valid = 0; local_out_valid = 0;
    check("half_tx_valid", local_in_valid, 1);
    check("half_rx_valid", rx_valid, 1);
    #2 rst = 1'b1;
    #1 check_idle_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_empty", local_in_valid, 0);
    check("post_rst_rx_empty", rx_valid, 0);
    local_in_busy = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
